mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage MIPSlite pipeline, directly downstream of the execute stage.
- Registers the execute results (ALU result, store data, branch decision, target address) and performs load/store against a word-addressed data memory with a fixed multi-cycle access latency.
- Issues the branch/jump redirect to fetch.
- Presents a single-cycle result pulse to write-back.
- Back-pressures execute with a ready signal while a memory access is in flight.

Parameters:
- DATA, 32, data/ALU word width
- ADDRESS_WIDTH, 32, PC/target address width
- REG_ADDR, 5, destination register index width
- MEM_DEPTH, 1024, data memory depth in words
- MEM_LAT, 2, memory access cycles (legal range 1..15)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept this cycle
- ex_alu_o  in  DATA  ALU result; memory byte address for load/store
- ex_write_data  in  DATA  store data
- ex_is_taken  in  1  branch/jump taken
- ex_new_addr  in  DATA  branch/jump target
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_reg_write  in  1  instruction writes a register
- ex_dest  in  REG_ADDR  destination register
- ex_halt  in  1  HALT instruction
- wb_valid  out  1  one-cycle result pulse
- wb_data  out  DATA  load data or ALU result
- wb_dest  out  REG_ADDR  destination register
- wb_reg_write  out  1  register write enable, qualified by wb_valid
- redirect_valid  out  1  one-cycle fetch redirect pulse
- redirect_addr  out  ADDRESS_WIDTH  redirect target
- mem_err  out  1  one-cycle pulse on misaligned/out-of-range access
- halted  out  1  sticky halt flag

Behaviour:
- Accept happens on a rising edge where ex_valid && ex_ready.
- ex_ready = (state==IDLE) && !halted. It is a combinational function of registered state only.
- FSM states: IDLE, ACCESS.
- IDLE, non-memory accept (neither mem_read nor mem_write): stay in IDLE. In the next cycle, wb_valid=1, wb_data=ex_alu_o, wb_dest=ex_dest, wb_reg_write=ex_reg_write && ex_dest!=0. Latency is 1.
- IDLE, memory accept with a legal address: latch address, data, type and dest; load counter with MEM_LAT-1; go to ACCESS. ex_ready is low for MEM_LAT cycles.
- ACCESS: decrement the counter each cycle. When the counter is 0, a store writes mem[addr>>2] and a load reads it. Return to IDLE on that edge. wb_valid pulses the next cycle. Memory latency is MEM_LAT+1 edges from the accepting edge.
- Store result: wb_reg_write=0 and wb_data=store address.
- Load result: wb_data = read word; wb_reg_write=ex_reg_write && dest!=0.
- Simultaneous load and store flags: treated as a store.
- Illegal address: addr[1:0]!=0 or (addr>>2)>=MEM_DEPTH.
  - No memory access; stay in IDLE.
  - Next cycle: mem_err=1, wb_valid=1, wb_reg_write=0, wb_data=ex_alu_o.
- Redirect: an accept with ex_is_taken=1 gives redirect_valid=1 in the next cycle, with redirect_addr = {ex_new_addr[ADDRESS_WIDTH-1:2],2'b00}. This is concurrent with wb_valid. A memory op never redirects; is_taken is ignored on loads and stores.
- Halt: an accept with ex_halt=1 sets halted on that edge. The halt instruction still produces wb_valid (with wb_reg_write=0). ex_ready stays low until reset.
- All pulse outputs are exactly one cycle wide and are 0 when no result is presented.
- Reset values: wb_valid, wb_data, wb_dest, wb_reg_write, redirect_valid, redirect_addr, mem_err and halted are all 0; state=IDLE; counter=0.
- Reset mid-ACCESS: the pending store is dropped (memory unchanged) and no wb_valid follows.
- Memory contents are not affected by reset; the bench preloads them hierarchically.

Optional Feature:
- Macro: MEM_STAGE_PERF_EN.
- Defined: adds outputs perf_mem_ops (32b), a count of completed legal loads and stores, and perf_stall_cycles (32b), a count of cycles with ex_valid && !ex_ready.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist.
- Core behaviour is identical either way.

Test Plan:
- ADD: alu_o=0x1234, dest=5, reg_write=1 → next cycle wb_valid=1, wb_data=0x1234, wb_reg_write=1, ex_ready stays high.
- Store then load, MEM_LAT=2: store 0xDEADBEEF @0x40 → ex_ready low 2 cycles, wb_reg_write=0. Then load @0x40, dest=3 → wb_data=0xDEADBEEF 3 edges after accept.
- Taken branch: is_taken=1, new_addr=0x00000103 → next cycle redirect_valid=1, redirect_addr=0x00000100, one-cycle pulse.
- Misaligned load @0x42 and out-of-range load @0x1000 (MEM_DEPTH=1024) → mem_err=1 next cycle, wb_reg_write=0, no ACCESS state.
- Assert rst mid-ACCESS of a store 0x55 @0x80 → all outputs 0 immediately, mem[0x20] unchanged, no wb_valid after reset release.
- HALT accepted → wb_valid pulse, halted=1, ex_ready=0 for 20 cycles with ex_valid held high. With MEM_STAGE_PERF_EN, perf_stall_cycles=20.

Source files
------------

// File: rtl/mem_stage_if.sv
// Execute-to-memory handshake plus the write-back, redirect and status
// outputs of the MIPSlite memory stage.
interface mem_stage_if #(
    parameter int unsigned DATA          = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned REG_ADDR      = 5
);
    logic                     ex_valid;
    logic                     ex_ready;
    logic [DATA-1:0]          ex_alu_o;
    logic [DATA-1:0]          ex_write_data;
    logic                     ex_is_taken;
    logic [DATA-1:0]          ex_new_addr;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_reg_write;
    logic [REG_ADDR-1:0]      ex_dest;
    logic                     ex_halt;

    logic                     wb_valid;
    logic [DATA-1:0]          wb_data;
    logic [REG_ADDR-1:0]      wb_dest;
    logic                     wb_reg_write;
    logic                     redirect_valid;
    logic [ADDRESS_WIDTH-1:0] redirect_addr;
    logic                     mem_err;
    logic                     halted;

    modport master (
        output ex_valid, ex_alu_o, ex_write_data, ex_is_taken, ex_new_addr,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_dest, ex_halt,
        input  ex_ready, wb_valid, wb_data, wb_dest, wb_reg_write,
               redirect_valid, redirect_addr, mem_err, halted
    );

    modport slave (
        input  ex_valid, ex_alu_o, ex_write_data, ex_is_taken, ex_new_addr,
               ex_mem_read, ex_mem_write, ex_reg_write, ex_dest, ex_halt,
        output ex_ready, wb_valid, wb_data, wb_dest, wb_reg_write,
               redirect_valid, redirect_addr, mem_err, halted
    );
endinterface

// File: rtl/mem_stage.sv
// MIPSlite memory stage: registers execute results, runs multi-cycle load/store,
// issues fetch redirects. Define MEM_STAGE_PERF_EN to add perf counters.
module mem_stage #(
    parameter int unsigned DATA          = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned REG_ADDR      = 5,
    parameter int unsigned MEM_DEPTH     = 1024,
    parameter int unsigned MEM_LAT       = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0] perf_mem_ops,
    output logic [31:0] perf_stall_cycles
`endif
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DATA-1:0]          addr_q, addr_d, wdata_q, wdata_d;
    logic                     store_q, store_d, rw_q, rw_d;
    logic [REG_ADDR-1:0]      dest_q, dest_d;
    logic                     wb_valid_q, wb_valid_d;
    logic [DATA-1:0]          wb_data_q, wb_data_d;
    logic [REG_ADDR-1:0]      wb_dest_q, wb_dest_d;
    logic                     wb_rw_q, wb_rw_d;
    logic                     redir_valid_q, redir_valid_d;
    logic [ADDRESS_WIDTH-1:0] redir_addr_q, redir_addr_d;
    logic                     mem_err_q, mem_err_d;
    logic                     halted_q, halted_d;
    logic                     accept_c, legal_c, is_mem_c, mem_we_c, mem_done_c;
    logic                     unused_c;

    logic [DATA-1:0]          mem [MEM_DEPTH];

    assign bus.ex_ready       = (state_q == IDLE) && !halted_q;
    assign bus.wb_valid       = wb_valid_q;
    assign bus.wb_data        = wb_data_q;
    assign bus.wb_dest        = wb_dest_q;
    assign bus.wb_reg_write   = wb_rw_q;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_addr  = redir_addr_q;
    assign bus.mem_err        = mem_err_q;
    assign bus.halted         = halted_q;

    assign accept_c = bus.ex_valid && bus.ex_ready;
    assign is_mem_c = bus.ex_mem_read || bus.ex_mem_write;
    assign legal_c  = (bus.ex_alu_o[1:0] == 2'b00) &&
                      (bus.ex_alu_o[DATA-1:2] < (DATA-2)'(MEM_DEPTH));
    assign unused_c = ^bus.ex_new_addr[1:0];

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        store_d       = store_q;
        rw_d          = rw_q;
        dest_d        = dest_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_dest_d     = wb_dest_q;
        wb_rw_d       = 1'b0;
        redir_valid_d = 1'b0;
        redir_addr_d  = redir_addr_q;
        mem_err_d     = 1'b0;
        halted_d      = halted_q;
        mem_we_c      = 1'b0;
        mem_done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (bus.ex_halt) halted_d = 1'b1;
                    if (!is_mem_c) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.ex_alu_o;
                        wb_dest_d  = bus.ex_dest;
                        wb_rw_d    = bus.ex_reg_write && (bus.ex_dest != '0) && !bus.ex_halt;
                        if (bus.ex_is_taken) begin
                            redir_valid_d = 1'b1;
                            redir_addr_d  = {bus.ex_new_addr[ADDRESS_WIDTH-1:2], 2'b00};
                        end
                    end else if (legal_c) begin
                        state_d = ACCESS;
                        cnt_d   = CNT_W'(MEM_LAT - 1);
                        addr_d  = bus.ex_alu_o;
                        wdata_d = bus.ex_write_data;
                        store_d = bus.ex_mem_write;
                        rw_d    = bus.ex_reg_write && !bus.ex_halt;
                        dest_d  = bus.ex_dest;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = bus.ex_alu_o;
                        wb_dest_d  = bus.ex_dest;
                        mem_err_d  = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d    = IDLE;
                    mem_done_c = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    if (store_q) begin
                        mem_we_c  = 1'b1;
                        wb_data_d = addr_q;
                    end else begin
                        wb_data_d = mem[addr_q[IDX_W+1:2]];
                        wb_rw_d   = rw_q && (dest_q != '0);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            store_q       <= 1'b0;
            rw_q          <= 1'b0;
            dest_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_dest_q     <= '0;
            wb_rw_q       <= 1'b0;
            redir_valid_q <= 1'b0;
            redir_addr_q  <= '0;
            mem_err_q     <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            store_q       <= store_d;
            rw_q          <= rw_d;
            dest_q        <= dest_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_dest_q     <= wb_dest_d;
            wb_rw_q       <= wb_rw_d;
            redir_valid_q <= redir_valid_d;
            redir_addr_q  <= redir_addr_d;
            mem_err_q     <= mem_err_d;
            halted_q      <= halted_d;
        end
    end

    // Data memory is not reset; a store cut off by reset never lands
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) mem[addr_q[IDX_W+1:2]] <= wdata_q;
    end

`ifdef MEM_STAGE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_mem_ops      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (mem_done_c && (perf_mem_ops != '1))
                perf_mem_ops <= perf_mem_ops + 32'(1);
            if (bus.ex_valid && !bus.ex_ready && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'(1);
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for single-cycle results plus
// hand sequences for load/store latency, reset mid-access and halt.
module tb_mem_stage;
    localparam int unsigned MEM_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_stage_if bus ();

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_mem_ops, perf_stall_cycles;
`endif

    mem_stage #(.MEM_LAT(MEM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef MEM_STAGE_PERF_EN
        ,
        .perf_mem_ops      (perf_mem_ops),
        .perf_stall_cycles (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic        taken;
        logic [31:0] na;
        logic        rd;
        logic        wr;
        logic        rw;
        logic [4:0]  dest;
        logic        e_rw;
        logic        e_redir;
        logic [31:0] e_raddr;
        logic        e_err;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.ex_valid      = 1'b0;
        bus.ex_alu_o      = '0;
        bus.ex_write_data = '0;
        bus.ex_is_taken   = 1'b0;
        bus.ex_new_addr   = '0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_mem_write  = 1'b0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_dest       = '0;
        bus.ex_halt       = 1'b0;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] wdata, input logic taken,
                         input logic [31:0] na, input logic rd, input logic wr, input logic rw,
                         input logic [4:0] dest, input logic halt);
        bus.ex_valid      = 1'b1;
        bus.ex_alu_o      = alu;
        bus.ex_write_data = wdata;
        bus.ex_is_taken   = taken;
        bus.ex_new_addr   = na;
        bus.ex_mem_read   = rd;
        bus.ex_mem_write  = wr;
        bus.ex_reg_write  = rw;
        bus.ex_dest       = dest;
        bus.ex_halt       = halt;
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Legal memory op: check latency, ready-low window and the result pulse
    task automatic mem_op(input string name, input logic rd, input logic wr, input logic [31:0] alu,
                          input logic [31:0] wdata, input logic [4:0] dest, input logic rw,
                          input logic [31:0] e_data, input logic e_rw);
        int n;
        int lows;
        drive(alu, wdata, 1'b1, 32'h0000_0500, rd, wr, rw, dest, 1'b0);
        cycle();
        idle_bus();
        n = 1;
        lows = 0;
        while (!bus.wb_valid && n < 12) begin
            if (!bus.ex_ready) lows++;
            cycle();
            n++;
        end
        chk({name, " latency"}, 32'(n), 32'(MEM_LAT + 1));
        chk({name, " ready_low"}, 32'(lows), 32'(MEM_LAT));
        chk({name, " wb_data"}, bus.wb_data, e_data);
        chk({name, " wb_dest"}, 32'(bus.wb_dest), 32'(dest));
        chk({name, " wb_reg_write"}, 32'(bus.wb_reg_write), 32'(e_rw));
        chk({name, " no_redirect"}, 32'(bus.redirect_valid), 32'd0);
        chk({name, " mem_err"}, 32'(bus.mem_err), 32'd0);
        chk({name, " ready_back"}, 32'(bus.ex_ready), 32'd1);
        cycle();
        chk({name, " pulse_end"}, 32'(bus.wb_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_wb;
        int cnt_rdy;

        vecs[0] = '{32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 32'h0, 1'b0};
        vecs[1] = '{32'h0000_ABCD, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0,  1'b0, 1'b0, 32'h0, 1'b0};
        vecs[2] = '{32'h0000_0005, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 32'h0, 1'b0};
        vecs[3] = '{32'h0000_0077, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
        vecs[4] = '{32'h0000_0044, 1'b1, 32'h2000_0006, 1'b0, 1'b0, 1'b1, 5'd31, 1'b1, 1'b1, 32'h2000_0004, 1'b0};
        vecs[5] = '{32'h0000_0042, 1'b1, 32'h0000_0300, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[6] = '{32'h0000_1000, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 32'h0, 1'b1};
        vecs[7] = '{32'h0000_0003, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[8] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2,  1'b0, 1'b0, 32'h0, 1'b1};
        vecs[9] = '{32'h0000_0FFE, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1,  1'b0, 1'b0, 32'h0, 1'b1};

        rst = 1'b1;
        idle_bus();
        @(negedge clk);
        @(negedge clk);
        chk("rst wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst wb_data", bus.wb_data, 32'd0);
        chk("rst wb_dest", 32'(bus.wb_dest), 32'd0);
        chk("rst wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        chk("rst redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst redirect_addr", bus.redirect_addr, 32'd0);
        chk("rst mem_err", 32'(bus.mem_err), 32'd0);
        chk("rst halted", 32'(bus.halted), 32'd0);
        chk("rst ex_ready", 32'(bus.ex_ready), 32'd1);
`ifdef MEM_STAGE_PERF_EN
        chk("rst perf_mem_ops", perf_mem_ops, 32'd0);
        chk("rst perf_stall", perf_stall_cycles, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].alu, 32'hAAAA_5555, vecs[i].taken, vecs[i].na, vecs[i].rd,
                  vecs[i].wr, vecs[i].rw, vecs[i].dest, 1'b0);
            cycle();
            idle_bus();
            chk($sformatf("v%0d wb_valid", i), 32'(bus.wb_valid), 32'd1);
            chk($sformatf("v%0d wb_data", i), bus.wb_data, vecs[i].alu);
            chk($sformatf("v%0d wb_dest", i), 32'(bus.wb_dest), 32'(vecs[i].dest));
            chk($sformatf("v%0d wb_reg_write", i), 32'(bus.wb_reg_write), 32'(vecs[i].e_rw));
            chk($sformatf("v%0d redirect_valid", i), 32'(bus.redirect_valid), 32'(vecs[i].e_redir));
            if (vecs[i].e_redir)
                chk($sformatf("v%0d redirect_addr", i), bus.redirect_addr, vecs[i].e_raddr);
            chk($sformatf("v%0d mem_err", i), 32'(bus.mem_err), 32'(vecs[i].e_err));
            chk($sformatf("v%0d ex_ready", i), 32'(bus.ex_ready), 32'd1);
            cycle();
            chk($sformatf("v%0d pulses_clear", i),
                32'({bus.wb_valid, bus.wb_reg_write, bus.redirect_valid, bus.mem_err}), 32'd0);
        end

        mem_op("st40",   1'b0, 1'b1, 32'h40,  32'hDEAD_BEEF, 5'd7, 1'b1, 32'h40, 1'b0);
        mem_op("ld40",   1'b1, 1'b0, 32'h40,  32'h0,         5'd3, 1'b1, 32'hDEAD_BEEF, 1'b1);
        mem_op("rdwr44", 1'b1, 1'b1, 32'h44,  32'h1234_5678, 5'd4, 1'b1, 32'h44, 1'b0);
        mem_op("ld44d0", 1'b1, 1'b0, 32'h44,  32'h0,         5'd0, 1'b1, 32'h1234_5678, 1'b0);
        mem_op("stFFC",  1'b0, 1'b1, 32'hFFC, 32'h0BAD_F00D, 5'd9, 1'b0, 32'hFFC, 1'b0);
        mem_op("ldFFC",  1'b1, 1'b0, 32'hFFC, 32'h0,         5'd2, 1'b1, 32'h0BAD_F00D, 1'b1);
        mem_op("st80",   1'b0, 1'b1, 32'h80,  32'h1111_1111, 5'd1, 1'b0, 32'h80, 1'b0);
`ifdef MEM_STAGE_PERF_EN
        chk("perf_mem_ops pre_rst", perf_mem_ops, 32'd7);
        chk("perf_stall pre_rst", perf_stall_cycles, 32'd0);
`endif

        // Reset lands while a store is still in flight
        drive(32'h80, 32'h0000_0055, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0);
        cycle();
        idle_bus();
        chk("midrst in_access", 32'(bus.ex_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("midrst wb_data", bus.wb_data, 32'd0);
        chk("midrst redirect_addr", bus.redirect_addr, 32'd0);
        chk("midrst ex_ready", 32'(bus.ex_ready), 32'd1);
        cycle();
        rst = 1'b0;
        cnt_wb = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (bus.wb_valid) cnt_wb++;
        end
        chk("midrst no_wb", 32'(cnt_wb), 32'd0);
        mem_op("ld80", 1'b1, 1'b0, 32'h80, 32'h0, 5'd6, 1'b1, 32'h1111_1111, 1'b1);

        // Halt, then hold ex_valid high against a closed stage
        drive(32'h99, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, 1'b1);
        cycle();
        bus.ex_halt = 1'b0;
        chk("halt wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("halt wb_reg_write", 32'(bus.wb_reg_write), 32'd0);
        chk("halt halted", 32'(bus.halted), 32'd1);
        chk("halt ex_ready", 32'(bus.ex_ready), 32'd0);
        cnt_wb = 0;
        cnt_rdy = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.wb_valid) cnt_wb++;
            if (bus.ex_ready) cnt_rdy++;
        end
        chk("halt ready_stays_low", 32'(cnt_rdy), 32'd0);
        chk("halt no_more_wb", 32'(cnt_wb), 32'd0);
        chk("halt sticky", 32'(bus.halted), 32'd1);
`ifdef MEM_STAGE_PERF_EN
        chk("perf_stall halt", perf_stall_cycles, 32'd20);
        chk("perf_mem_ops post_rst", perf_mem_ops, 32'd1);
`endif
        idle_bus();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
